// File: rtl/uart_transmitter_top.sv
// UART transmitter: THR -> TSR serialiser, 5-8 data bits, parity, 1/1.5/2 stop bits.
// Optional break support is compiled in with `define UART_TX_BREAK_EN.
module uart_transmitter_top #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       uttrst,
    input  logic       baud_edge,
    input  logic [7:0] thr_data,
    input  logic       thr_valid,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    input  logic       stb,
    input  logic       bc,
    input  logic       loop,
    output logic       uart_txd,
    output logic       loop_txd,
    output logic       tx_load_en,
    output logic       tsr_empty
);

    localparam int CW = $clog2(2 * OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tsr_q, tsr_d;
    logic [1:0]    wls_q, wls_d;
    logic          pen_q, pen_d;
    logic          stb_q, stb_d;
    logic          par_q, par_d;
    logic          txd_q, txd_d;
    logic          ltxd_q, ltxd_d;

    logic [CW-1:0] lim;
    logic          bit_end;
    logic          load;
    logic [7:0]    mask;
    logic          par_calc;
    logic          ser;

    always_comb begin
        mask = 8'hFF;
        unique case (wls)
            2'b00:   mask = 8'h1F;
            2'b01:   mask = 8'h3F;
            2'b10:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
    end

    // Parity is resolved at load time from the live line-control inputs
    assign par_calc = sp  ? ~eps :
                      eps ? ^(thr_data & mask) : ~^(thr_data & mask);

    always_comb begin
        lim = CW'(OVERSAMPLE - 1);
        if (state_q == STOP && stb_q) begin
            if (wls_q == 2'b00) lim = CW'(OVERSAMPLE * 3 / 2 - 1);
            else                lim = CW'(2 * OVERSAMPLE - 1);
        end
    end

    assign bit_end = baud_edge && (tick_q == lim);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        tsr_d   = tsr_q;
        wls_d   = wls_q;
        pen_d   = pen_q;
        stb_d   = stb_q;
        par_d   = par_q;
        load    = 1'b0;

        if (state_q != IDLE && baud_edge) begin
            tick_d = bit_end ? '0 : tick_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                tick_d = '0;
                if (thr_valid) load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    tsr_d = {1'b0, tsr_q[7:1]};
                    if (bit_q == {1'b1, wls_q}) begin
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (thr_valid) load = 1'b1;
                    else           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = START;
            tick_d  = '0;
            bit_d   = 3'd0;
            tsr_d   = thr_data;
            wls_d   = wls;
            pen_d   = pen;
            stb_d   = stb;
            par_d   = par_calc;
        end
    end

    // Line level follows the next state so the start bit appears right after the load edge
    always_comb begin
        ser = 1'b1;
        unique case (state_d)
            START:   ser = 1'b0;
            DATA:    ser = tsr_d[0];
            PARITY:  ser = par_d;
            default: ser = 1'b1;
        endcase
    end

`ifdef UART_TX_BREAK_EN
    always_comb begin
        txd_d  = loop ? 1'b1 : (bc ? 1'b0 : ser);
        ltxd_d = (loop && bc) ? 1'b0 : ser;
    end
`else
    logic unused_bc;
    assign unused_bc = bc;

    always_comb begin
        txd_d  = loop ? 1'b1 : ser;
        ltxd_d = ser;
    end
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            tsr_q   <= 8'h00;
            wls_q   <= 2'b00;
            pen_q   <= 1'b0;
            stb_q   <= 1'b0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ltxd_q  <= 1'b1;
        end else if (uttrst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            tsr_q   <= 8'h00;
            wls_q   <= 2'b00;
            pen_q   <= 1'b0;
            stb_q   <= 1'b0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ltxd_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            tsr_q   <= tsr_d;
            wls_q   <= wls_d;
            pen_q   <= pen_d;
            stb_q   <= stb_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ltxd_q  <= ltxd_d;
        end
    end

    assign tx_load_en = load && !uttrst;
    assign tsr_empty  = (state_q == IDLE) && !tx_load_en;
    assign uart_txd   = txd_q;
    assign loop_txd   = ltxd_q;

endmodule
